// File: rtl/cpu_sequencer_pkg.sv
// FourBitCPU shared defines: opcodes, ALU selects,
// sequencer state encoding and the IR layout.
package cpu_sequencer_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_HLT      = 4'b1101;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] imm;
  } instr_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer bundle: ROM/decoder inputs and
// PC/IR/strobe/status outputs.
interface cpu_sequencer_if #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
);
  logic             run;
  logic             step;
  logic [7:0]       instr_in;
  logic             carry_in;
  logic             dec_a_load;
  logic             dec_b_load;
  logic [PC_W-1:0]  pc_out;
  logic [3:0]       op_out;
  logic [3:0]       imm_out;
  logic             reg_a_load;
  logic             reg_b_load;
  logic             carry_flag;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  run, step, instr_in, carry_in,
    input  dec_a_load, dec_b_load,
    output pc_out, op_out, imm_out,
    output reg_a_load, reg_b_load,
    output carry_flag, busy, halted, retired
  );

  modport master (
    output run, step, instr_in, carry_in,
    output dec_a_load, dec_b_load,
    input  pc_out, op_out, imm_out,
    input  reg_a_load, reg_b_load,
    input  carry_flag, busy, halted, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXEC sequencer owning PC, IR and carry;
// gates decoder load strobes to the EXEC cycle.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.slave  bus_if
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  instr_t           ir_q, ir_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             step_pend_q, step_pend_d;

  logic            in_exec;
  logic            is_jmp, is_jnc, is_hlt;
  logic [PC_W-1:0] pc_inc, pc_tgt;

  assign in_exec = (state_q == ST_EXEC);
  assign is_jmp  = (ir_q.op == OP_JMP);
  assign is_jnc  = (ir_q.op == OP_JNC);
  assign is_hlt  = (ir_q.op == OP_HLT);
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_tgt  = PC_W'(ir_q.imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      carry_q     <= 1'b0;
      retired_q   <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      carry_q     <= carry_d;
      retired_q   <= retired_d;
      step_pend_q <= step_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    carry_d     = carry_q;
    retired_d   = retired_q;
    step_pend_d = step_pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.run || bus_if.step) begin
          state_d     = ST_FETCH;
          step_pend_d = bus_if.step && !bus_if.run;
        end
      end
      ST_FETCH: begin
        ir_d    = instr_t'(bus_if.instr_in);
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        carry_d     = bus_if.carry_in;
        step_pend_d = 1'b0;
        if (retired_q != '1)
          retired_d = retired_q + CNT_W'(1);
        unique case (1'b1)
          is_jmp:  pc_d = pc_tgt;
          // JNC tests the flag left by the previous EXEC
          is_jnc:  pc_d = carry_q ? pc_inc : pc_tgt;
          is_hlt:  pc_d = pc_q;
          default: pc_d = pc_inc;
        endcase
        if (is_hlt)
          state_d = ST_HALT;
        else if (bus_if.run && !step_pend_q)
          state_d = ST_FETCH;
        else
          state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.pc_out     = pc_q;
  assign bus_if.op_out     = ir_q.op;
  assign bus_if.imm_out    = ir_q.imm;
  assign bus_if.reg_a_load = bus_if.dec_a_load & in_exec;
  assign bus_if.reg_b_load = bus_if.dec_b_load & in_exec;
  assign bus_if.carry_flag = carry_q;
  assign bus_if.busy       = (state_q == ST_FETCH)
                           | (state_q == ST_DECODE)
                           | in_exec;
  assign bus_if.halted     = (state_q == ST_HALT);
  assign bus_if.retired    = retired_q;

endmodule
